// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// ALU operations, immediate formats and datapath mux selects.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_EXEC_R = 4'd2;
    localparam logic [3:0] ST_EXEC_I = 4'd3;
    localparam logic [3:0] ST_ADDR   = 4'd4;
    localparam logic [3:0] ST_BRANCH = 4'd5;
    localparam logic [3:0] ST_LUI    = 4'd6;
    localparam logic [3:0] ST_AUIPC  = 4'd7;
    localparam logic [3:0] ST_JAL    = 4'd8;
    localparam logic [3:0] ST_JALR   = 4'd9;
    localparam logic [3:0] ST_MEM    = 4'd10;
    localparam logic [3:0] ST_WB     = 4'd11;
    localparam logic [3:0] ST_TRAP   = 4'd12;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    // How the ALU operation is chosen in the current state
    typedef enum logic [1:0] {
        CLS_ADD    = 2'd0,
        CLS_R      = 2'd1,
        CLS_I      = 2'd2,
        CLS_BRANCH = 2'd3
    } alu_class_e;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_RS1    = 2'd1;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd2;
    localparam logic [1:0] SRC_A_ZERO   = 2'd3;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational map from (ALU class, funct3, funct7[5]) to the ALU operation,
// plus a flag for the branch funct3 codes RV32I leaves undefined.
module alu_op_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_class,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_op,
    output logic       branch_unsupported
);

    always_comb begin
        alu_op             = ALU_ADD;
        branch_unsupported = 1'b0;
        case (alu_class)
            CLS_R, CLS_I: begin
                case (funct3)
                    3'b000:  alu_op = (alu_class == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            CLS_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: alu_op = ALU_SUB;
                    3'b100, 3'b101: alu_op = ALU_SLT;
                    3'b110, 3'b111: alu_op = ALU_SLTU;
                    default: begin
                        alu_op             = ALU_SUB;
                        branch_unsupported = 1'b1;
                    end
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main control FSM: fetch, decode, execute, memory, writeback.
// Outputs decode from the registered state; only enables look at READY inputs.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter logic RESET_TRAP_CLEAR = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNCT3,
    input  logic       FUNCT7_5,
    input  logic       ZERO,
    input  logic       LT,
    output logic       IMEM_REQ,
    input  logic       IMEM_READY,
    output logic       DMEM_REQ,
    output logic       DMEM_WE,
    input  logic       DMEM_READY,
    output logic       IR_WRITE,
    output logic       PC_WRITE,
    output logic [1:0] PC_SRC,
    output logic [1:0] ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic [3:0] ALU_OP,
    output logic [2:0] IMM_SEL,
    output logic       REG_WRITE,
    output logic [1:0] WB_SEL,
    output logic       ILLEGAL,
    output logic [3:0] STATE_DBG
);

    logic [3:0] state_reg, state_next;
    logic       illegal_reg, illegal_next;
    logic [1:0] alu_class;
    logic [3:0] dec_alu_op;
    logic       branch_unsupported;
    logic       is_load, is_store, is_jump, branch_taken;

    assign is_load  = (OPCODE == OPC_LOAD);
    assign is_store = (OPCODE == OPC_STORE);
    assign is_jump  = (OPCODE == OPC_JAL) || (OPCODE == OPC_JALR);
    // funct3[2] picks the LT flag over ZERO, funct3[0] inverts the condition
    assign branch_taken = (FUNCT3[2] ? LT : ZERO) ^ FUNCT3[0];

    alu_op_decoder u_alu_op_decoder (
        .alu_class          (alu_class),
        .funct3             (FUNCT3),
        .funct7_5           (FUNCT7_5),
        .alu_op             (dec_alu_op),
        .branch_unsupported (branch_unsupported)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH:  if (IMEM_READY) state_next = ST_DECODE;
            ST_DECODE: begin
                case (OPCODE)
                    OPC_OP:               state_next = ST_EXEC_R;
                    OPC_OP_IMM:           state_next = ST_EXEC_I;
                    OPC_LOAD, OPC_STORE:  state_next = ST_ADDR;
                    OPC_BRANCH:           state_next = ST_BRANCH;
                    OPC_LUI:              state_next = ST_LUI;
                    OPC_AUIPC:            state_next = ST_AUIPC;
                    OPC_JAL:              state_next = ST_JAL;
                    OPC_JALR:             state_next = ST_JALR;
                    default:              state_next = ST_TRAP;
                endcase
            end
            ST_EXEC_R, ST_EXEC_I, ST_LUI, ST_AUIPC, ST_JAL, ST_JALR:
                state_next = ST_WB;
            ST_ADDR:   state_next = ST_MEM;
            ST_BRANCH: state_next = branch_unsupported ? ST_TRAP : ST_FETCH;
            ST_MEM: begin
                if (DMEM_READY) state_next = is_store ? ST_FETCH : ST_WB;
            end
            ST_WB:     state_next = ST_FETCH;
            ST_TRAP:   state_next = ST_TRAP;
            default:   state_next = ST_FETCH;
        endcase
    end

    assign illegal_next = illegal_reg || (state_next == ST_TRAP);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_FETCH;
            if (RESET_TRAP_CLEAR) begin
                illegal_reg <= 1'b0;
            end
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
        end
    end

    // While RST is high every enable and select is held at its quiescent 0
    always_comb begin
        IMEM_REQ  = 1'b0;
        DMEM_REQ  = 1'b0;
        DMEM_WE   = 1'b0;
        IR_WRITE  = 1'b0;
        PC_WRITE  = 1'b0;
        REG_WRITE = 1'b0;
        PC_SRC    = PC_SRC_ALU;
        ALU_SRC_A = SRC_A_PC;
        ALU_SRC_B = SRC_B_RS2;
        IMM_SEL   = IMM_I;
        WB_SEL    = WB_ALUOUT;
        alu_class = CLS_ADD;
        if (!RST) begin
            case (state_reg)
                ST_FETCH: begin
                    IMEM_REQ  = 1'b1;
                    ALU_SRC_B = SRC_B_FOUR;
                    IR_WRITE  = IMEM_READY;
                    PC_WRITE  = IMEM_READY;
                end
                ST_DECODE: begin
                    ALU_SRC_A = SRC_A_OLD_PC;
                    ALU_SRC_B = SRC_B_IMM;
                    IMM_SEL   = IMM_B;
                end
                ST_EXEC_R: begin
                    ALU_SRC_A = SRC_A_RS1;
                    ALU_SRC_B = SRC_B_RS2;
                    alu_class = CLS_R;
                end
                ST_EXEC_I: begin
                    ALU_SRC_A = SRC_A_RS1;
                    ALU_SRC_B = SRC_B_IMM;
                    alu_class = CLS_I;
                end
                // MEM keeps the address computation unchanged while waiting
                ST_ADDR, ST_MEM: begin
                    ALU_SRC_A = SRC_A_RS1;
                    ALU_SRC_B = SRC_B_IMM;
                    IMM_SEL   = is_store ? IMM_S : IMM_I;
                    if (state_reg == ST_MEM) begin
                        DMEM_REQ = 1'b1;
                        DMEM_WE  = is_store;
                    end
                end
                ST_BRANCH: begin
                    ALU_SRC_A = SRC_A_RS1;
                    ALU_SRC_B = SRC_B_RS2;
                    IMM_SEL   = IMM_B;
                    alu_class = CLS_BRANCH;
                    PC_SRC    = PC_SRC_ALUOUT;
                    PC_WRITE  = branch_taken && !branch_unsupported;
                end
                ST_LUI: begin
                    ALU_SRC_A = SRC_A_ZERO;
                    ALU_SRC_B = SRC_B_IMM;
                    IMM_SEL   = IMM_U;
                end
                ST_AUIPC: begin
                    ALU_SRC_A = SRC_A_OLD_PC;
                    ALU_SRC_B = SRC_B_IMM;
                    IMM_SEL   = IMM_U;
                end
                ST_JAL: begin
                    ALU_SRC_A = SRC_A_OLD_PC;
                    ALU_SRC_B = SRC_B_IMM;
                    IMM_SEL   = IMM_J;
                    PC_SRC    = PC_SRC_ALU;
                    PC_WRITE  = 1'b1;
                end
                ST_JALR: begin
                    ALU_SRC_A = SRC_A_RS1;
                    ALU_SRC_B = SRC_B_IMM;
                    IMM_SEL   = IMM_I;
                    PC_SRC    = PC_SRC_JALR;
                    PC_WRITE  = 1'b1;
                end
                ST_WB: begin
                    REG_WRITE = 1'b1;
                    WB_SEL    = is_load ? WB_MEM : (is_jump ? WB_PC4 : WB_ALUOUT);
                end
                default: ;
            endcase
        end
    end

    assign ALU_OP    = dec_alu_op;
    assign ILLEGAL   = illegal_reg;
    assign STATE_DBG = state_reg;

endmodule
